// File: rtl/resp_capture_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : resp_capture_checker_if
//  Brief    : Beat bus carrying (stimulus vector, DUT response) pairs into the
//             response capture checker.
//  Revision : 1.0  initial release
// ============================================================================
interface resp_capture_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic [N_OUT-1:0] in_resp;

    modport master (
        output in_valid,
        output in_vec,
        output in_resp,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  in_resp,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/resp_capture_checker.sv
`default_nettype none
// ============================================================================
//  Module   : resp_capture_checker
//  Brief    : Compares captured DUT responses against a golden table, counts
//             mismatches, compacts beats into a MISR and issues a verdict once
//             the full 2**N_IN vector space has been covered.
//  Revision : 1.0  initial release
// ============================================================================
module resp_capture_checker #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) (
    input  wire logic             CK,
    input  wire logic             reset,
    input  wire logic             gold_we,
    input  wire logic [N_IN-1:0]  gold_addr,
    input  wire logic [N_OUT-1:0] gold_data,
    input  wire logic             start,
    resp_capture_checker_if.slave beat,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         mism_count,
    output logic                  dup_err,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic                  first_fail_vld,
    output logic [15:0]           signature
);

    localparam int          c_DEPTH = 1 << N_IN;
    localparam logic [15:0] c_POLY  = 16'h1021;
    localparam logic [15:0] c_SEED  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [N_OUT-1:0]     r_gold [c_DEPTH];
    logic [c_DEPTH-1:0]   r_cov;
    logic [N_IN:0]        r_mism;
    logic                 r_dup;
    logic [N_IN-1:0]      r_ffv;
    logic                 r_ffvld;
    logic [15:0]          r_sig;

    logic                 w_not_run;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_mismatch;
    logic [c_DEPTH-1:0]   w_vec_bit;
    logic [c_DEPTH-1:0]   w_cov_next;
    logic                 w_complete;
    logic [15:0]          w_beat;
    logic [15:0]          w_sig_next;

    assign w_not_run  = (r_state != S_RUN);
    assign w_start    = start && w_not_run;
    assign w_accept   = beat.in_valid && beat.in_ready;
    assign w_mismatch = (beat.in_resp != r_gold[beat.in_vec]);
    assign w_vec_bit  = {{(c_DEPTH-1){1'b0}}, 1'b1} << beat.in_vec;
    assign w_cov_next = r_cov | w_vec_bit;
    assign w_complete = w_accept && (&w_cov_next);
    assign w_beat     = 16'({beat.in_vec, beat.in_resp});
    assign w_sig_next = ((r_sig << 1) ^ (r_sig[15] ? c_POLY : 16'h0000)) ^ w_beat;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_next = S_RUN;
            S_RUN:   if (w_complete) w_state_next = S_DONE;
            S_DONE:  if (start)      w_state_next = S_RUN;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // Table is frozen during a run; a write coinciding with start lands before the first beat.
    always_ff @(posedge CK) begin
        if (gold_we && w_not_run) begin
            r_gold[gold_addr] <= gold_data;
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_cov   <= '0;
            r_mism  <= '0;
            r_dup   <= 1'b0;
            r_ffv   <= '0;
            r_ffvld <= 1'b0;
            r_sig   <= c_SEED;
        end else if (w_start) begin
            r_cov   <= '0;
            r_mism  <= '0;
            r_dup   <= 1'b0;
            r_ffv   <= '0;
            r_ffvld <= 1'b0;
            r_sig   <= c_SEED;
        end else if (w_accept) begin
            r_cov <= w_cov_next;
            r_sig <= w_sig_next;
            if ((r_cov & w_vec_bit) != '0) begin
                r_dup <= 1'b1;
            end
            if (w_mismatch) begin
                if (r_mism != '1) begin
                    r_mism <= r_mism + 1'b1;
                end
                if (!r_ffvld) begin
                    r_ffv   <= beat.in_vec;
                    r_ffvld <= 1'b1;
                end
            end
        end
    end

    assign beat.in_ready  = (r_state == S_RUN);
    assign busy           = (r_state == S_RUN);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_mism == '0) && !r_dup;
    assign mism_count     = r_mism;
    assign dup_err        = r_dup;
    assign first_fail_vec = r_ffv;
    assign first_fail_vld = r_ffvld;
    assign signature      = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_resp_capture_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_resp_capture_checker
//  Brief    : Directed vector bench for resp_capture_checker (N_IN=3, N_OUT=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_resp_capture_checker;

    logic        CK;
    logic        reset;
    logic        gold_we;
    logic [2:0]  gold_addr;
    logic [0:0]  gold_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  mism_count;
    logic        dup_err;
    logic [2:0]  first_fail_vec;
    logic        first_fail_vld;
    logic [15:0] signature;

    int          checks;
    int          errors;
    logic [15:0] sig_m;

    resp_capture_checker_if #(.N_IN(3), .N_OUT(1)) bif ();

    resp_capture_checker #(.N_IN(3), .N_OUT(1)) dut (
        .CK             (CK),
        .reset          (reset),
        .gold_we        (gold_we),
        .gold_addr      (gold_addr),
        .gold_data      (gold_data),
        .start          (start),
        .beat           (bif.slave),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mism_count     (mism_count),
        .dup_err        (dup_err),
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld),
        .signature      (signature)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct packed {
        logic [8:0][2:0] vecs;
        logic [8:0]      flip;
        logic [3:0]      n;
        logic [3:0]      exp_mism;
        logic [2:0]      exp_ffv;
        logic            exp_ffvld;
        logic            exp_dup;
        logic            exp_pass;
    } run_t;

    run_t tbl [4];

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [2:0] v, input logic r);
        return ((s << 1) ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {12'h000, v, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called and returns at a negedge; the posedge in between accepts the beat.
    task automatic send(input logic [2:0] v, input logic r, input int gap);
        repeat (gap) @(negedge CK);
        bif.in_vec   = v;
        bif.in_resp  = r;
        bif.in_valid = 1'b1;
        chk("in_ready_at_beat", {31'd0, bif.in_ready}, 32'd1);
        @(negedge CK);
        bif.in_valid = 1'b0;
        sig_m = misr(sig_m, v, r);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        sig_m = 16'hFFFF;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic good_run();
        for (int v = 0; v < 8; v++) send(3'(v), ^(3'(v)), 0);
    endtask

    task automatic end_chk(input string tag, input logic [3:0] m, input logic dp, input logic ps);
        chk({tag, "_done"},  {31'd0, done}, 32'd1);
        chk({tag, "_ready"}, {31'd0, bif.in_ready}, 32'd0);
        chk({tag, "_mism"},  {28'd0, mism_count}, {28'd0, m});
        chk({tag, "_dup"},   {31'd0, dup_err}, {31'd0, dp});
        chk({tag, "_pass"},  {31'd0, pass}, {31'd0, ps});
        chk({tag, "_sig"},   {16'd0, signature}, {16'd0, sig_m});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sig_m  = 16'hFFFF;
        reset  = 1'b1;
        gold_we = 1'b0;
        gold_addr = '0;
        gold_data = '0;
        start = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_vec   = '0;
        bif.in_resp  = '0;

        tbl[0] = '{vecs: {3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, flip: 9'b000000000,
                   n: 4'd8, exp_mism: 4'd0, exp_ffv: 3'd0, exp_ffvld: 1'b0, exp_dup: 1'b0, exp_pass: 1'b1};
        tbl[1] = '{vecs: {3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, flip: 9'b001001000,
                   n: 4'd8, exp_mism: 4'd2, exp_ffv: 3'd3, exp_ffvld: 1'b1, exp_dup: 1'b0, exp_pass: 1'b0};
        tbl[2] = '{vecs: {3'd7,3'd6,3'd4,3'd3,3'd2,3'd1,3'd0,3'd5,3'd5}, flip: 9'b000000000,
                   n: 4'd9, exp_mism: 4'd0, exp_ffv: 3'd0, exp_ffvld: 1'b0, exp_dup: 1'b1, exp_pass: 1'b0};
        tbl[3] = '{vecs: {3'd0,3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}, flip: 9'b010000000,
                   n: 4'd8, exp_mism: 4'd1, exp_ffv: 3'd0, exp_ffvld: 1'b1, exp_dup: 1'b0, exp_pass: 1'b0};

        // Reset state
        #5 reset = 1'b0;
        #2;
        chk("rst_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("rst_sig",   {16'd0, signature}, 32'h0000FFFF);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_mism",  {28'd0, mism_count}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        @(negedge CK);
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);

        // Golden table: gold[v] = ^v
        for (int v = 0; v < 8; v++) begin
            gold_we = 1'b1;
            gold_addr = 3'(v);
            gold_data = ^(3'(v));
            @(negedge CK);
        end
        gold_we = 1'b0;

        for (int s = 0; s < 4; s++) begin
            do_start();
            for (int k = 0; k < int'(tbl[s].n); k++) begin
                if (k == int'(tbl[s].n) - 1)
                    chk($sformatf("run%0d_not_done_early", s), {31'd0, done}, 32'd0);
                send(tbl[s].vecs[k], (^tbl[s].vecs[k]) ^ tbl[s].flip[k], (k + s) % 4);
            end
            end_chk($sformatf("run%0d", s), tbl[s].exp_mism, tbl[s].exp_dup, tbl[s].exp_pass);
            chk($sformatf("run%0d_ffvld", s), {31'd0, first_fail_vld}, {31'd0, tbl[s].exp_ffvld});
            if (tbl[s].exp_ffvld)
                chk($sformatf("run%0d_ffv", s), {29'd0, first_fail_vec}, {29'd0, tbl[s].exp_ffv});
        end

        // Saturation: 16 mismatching vec-0 beats plus 7 mismatching others
        do_start();
        for (int k = 0; k < 16; k++) send(3'd0, 1'b1, 0);
        for (int v = 1; v < 8; v++) send(3'(v), ~(^(3'(v))), 0);
        end_chk("sat", 4'd15, 1'b1, 1'b0);
        chk("sat_ffv", {29'd0, first_fail_vec}, 32'd0);

        // in_valid outside RUN is ignored; DONE holds
        bif.in_valid = 1'b1;
        bif.in_vec   = 3'd2;
        bif.in_resp  = 1'b0;
        repeat (3) @(negedge CK);
        bif.in_valid = 1'b0;
        end_chk("done_hold", 4'd15, 1'b1, 1'b0);

        // Reset mid-run, then a clean run
        do_start();
        send(3'd1, 1'b0, 0);
        send(3'd1, 1'b0, 1);
        send(3'd2, 1'b1, 0);
        send(3'd3, 1'b1, 0);
        chk("pre_abort_mism", {28'd0, mism_count}, 32'd3);
        reset = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_mism",  {28'd0, mism_count}, 32'd0);
        chk("abort_dup",   {31'd0, dup_err}, 32'd0);
        chk("abort_ffvld", {31'd0, first_fail_vld}, 32'd0);
        chk("abort_sig",   {16'd0, signature}, 32'h0000FFFF);
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        chk("abort_idle_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        do_start();
        good_run();
        end_chk("after_abort", 4'd0, 1'b0, 1'b1);

        // gold_we during RUN ignored
        do_start();
        gold_we = 1'b1;
        gold_addr = 3'd0;
        gold_data = 1'b1;
        @(negedge CK);
        gold_we = 1'b0;
        good_run();
        end_chk("we_in_run", 4'd0, 1'b0, 1'b1);

        // gold_we with start in DONE lands before the run
        gold_we = 1'b1;
        gold_addr = 3'd0;
        gold_data = 1'b1;
        start = 1'b1;
        @(negedge CK);
        gold_we = 1'b0;
        start = 1'b0;
        sig_m = 16'hFFFF;
        send(3'd0, 1'b1, 0);
        for (int v = 1; v < 8; v++) send(3'(v), ^(3'(v)), 0);
        end_chk("we_in_done", 4'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
